// File: rtl/mem_bus_responder_pkg.sv
// Shared types and default geometry for the line-wide memory bus.
// mem_req_t / mem_rsp_t describe one request / one read response on a bus
// built with the default parameters below. The responder takes these
// defaults as its own parameter defaults.
package mem_bus_responder_pkg;

  localparam int MBR_DATA_SIZE      = 64;  // bytes per line
  localparam int MBR_ADDR_WIDTH     = 26;  // line address width
  localparam int MBR_MEM_LINES_LOG2 = 10;  // RAM depth log2
  localparam int MBR_TAG_WIDTH      = 8;
  localparam int MBR_LATENCY        = 4;   // read accept to earliest response
  localparam int MBR_QUEUE_SIZE     = 8;   // max outstanding reads

  typedef struct packed {
    logic                          rw;      // 1 = write
    logic [MBR_ADDR_WIDTH-1:0]     addr;
    logic [MBR_DATA_SIZE-1:0]      byteen;
    logic [8*MBR_DATA_SIZE-1:0]    data;
    logic [MBR_TAG_WIDTH-1:0]      tag;
  } mem_req_t;

  typedef struct packed {
    logic [8*MBR_DATA_SIZE-1:0]    data;
    logic [MBR_TAG_WIDTH-1:0]      tag;
  } mem_rsp_t;

endpackage

// File: rtl/mem_bus_responder_fifo.sv
// Response FIFO for the memory bus responder.
// Ports:
//   clk, reset  - clock, synchronous active-high reset (empties the queue)
//   push_i      - enqueue data_i (ignored when full; the owner guarantees space)
//   pop_i       - dequeue the head (ignored when empty)
//   data_i      - entry to enqueue
//   data_o      - current head entry, held stable until popped
//   empty_o     - queue holds no entries
module mem_bus_responder_fifo #(
  parameter int DEPTH = 8,
  parameter int DATAW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [DATAW-1:0] data_i,
  output logic [DATAW-1:0] data_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATAW-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && !full;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
    !(push_i && full));

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side slave for the line-wide memory bus.
// Backs read/write line requests with an internal line RAM and returns read
// responses in acceptance order after LATENCY cycles, with at most
// QUEUE_SIZE reads outstanding and backpressure on the response side.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   req_valid/req_ready - request handshake (fire = valid && ready)
//   req_rw              - 1 = write, 0 = read
//   req_addr            - line address (aliases modulo RAM depth)
//   req_byteen/req_data - write byte enables / write data
//   req_tag             - tag returned with the read response
//   rsp_valid/rsp_ready - response handshake
//   rsp_data/rsp_tag    - read line data and originating tag
//   busy                - at least one read outstanding
module mem_bus_responder
  import mem_bus_responder_pkg::*;
#(
  parameter int DATA_SIZE      = MBR_DATA_SIZE,
  parameter int ADDR_WIDTH     = MBR_ADDR_WIDTH,
  parameter int MEM_LINES_LOG2 = MBR_MEM_LINES_LOG2,
  parameter int TAG_WIDTH      = MBR_TAG_WIDTH,
  parameter int LATENCY        = MBR_LATENCY,
  parameter int QUEUE_SIZE     = MBR_QUEUE_SIZE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  input  logic                   req_rw,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_SIZE-1:0]   req_byteen,
  input  logic [8*DATA_SIZE-1:0] req_data,
  input  logic [TAG_WIDTH-1:0]   req_tag,
  output logic                   req_ready,
  output logic                   rsp_valid,
  output logic [8*DATA_SIZE-1:0] rsp_data,
  output logic [TAG_WIDTH-1:0]   rsp_tag,
  input  logic                   rsp_ready,
  output logic                   busy
);

  localparam int DATAW    = 8 * DATA_SIZE;
  localparam int CREDIT_W = $clog2(QUEUE_SIZE + 1);

  typedef struct packed {
    logic [DATAW-1:0]     data;
    logic [TAG_WIDTH-1:0] tag;
  } rsp_t;

  logic                      reset_q;
  logic [CREDIT_W-1:0]       credit_q, credit_d;
  logic [DATAW-1:0]          ram_q [2**MEM_LINES_LOG2];
  logic [MEM_LINES_LOG2-1:0] ram_idx;
  logic [DATAW-1:0]          ram_line;
  logic [DATAW-1:0]          wr_line;
  logic                      req_fire, wr_fire, rd_fire, rsp_pop;
  rsp_t                      rd_rsp;
  logic                      push_valid;
  rsp_t                      push_data;
  rsp_t                      head;
  logic                      fifo_empty;
  logic                      unused_addr_hi;

  // Upper address bits are ignored: lines alias modulo the RAM depth.
  assign ram_idx        = req_addr[MEM_LINES_LOG2-1:0];
  assign unused_addr_hi = ^req_addr[ADDR_WIDTH-1:MEM_LINES_LOG2];
  assign ram_line       = ram_q[ram_idx];

  // The credit counter covers both the delay line and the FIFO, so a
  // read can only be accepted when the FIFO is guaranteed to have room.
  assign req_ready = !reset_q && (credit_q < CREDIT_W'(QUEUE_SIZE));
  assign req_fire  = req_valid && req_ready && !reset;
  assign wr_fire   = req_fire && req_rw;
  assign rd_fire   = req_fire && !req_rw;
  assign rsp_valid = !fifo_empty;
  assign rsp_pop   = rsp_valid && rsp_ready;
  assign busy      = (credit_q != '0);

  always_ff @(posedge clk) begin
    reset_q <= reset;
  end

  // Byte-merge the write into the current line contents.
  for (genvar gi = 0; gi < DATA_SIZE; gi++) begin : g_byte_merge
    assign wr_line[gi*8 +: 8] = req_byteen[gi] ? req_data[gi*8 +: 8]
                                               : ram_line[gi*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (wr_fire) ram_q[ram_idx] <= wr_line;
  end

  // Reads sample the RAM combinationally at fire time.
  assign rd_rsp = '{data: ram_line, tag: req_tag};

  always_comb begin
    credit_d = credit_q;
    if (rd_fire && !rsp_pop)      credit_d = credit_q + CREDIT_W'(1);
    else if (!rd_fire && rsp_pop) credit_d = credit_q - CREDIT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) credit_q <= '0;
    else       credit_q <= credit_d;
  end

  // Delay line: LATENCY-1 registered stages, the FIFO register being the
  // last one, so a read fired at T is visible at rsp_valid at T+LATENCY.
  if (LATENCY == 1) begin : g_direct
    assign push_valid = rd_fire;
    assign push_data  = rd_rsp;
  end else begin : g_delay
    logic [LATENCY-2:0] stage_valid_q;
    rsp_t               stage_data_q [LATENCY-1];

    always_ff @(posedge clk) begin
      if (reset) begin
        stage_valid_q <= '0;
      end else begin
        stage_valid_q[0] <= rd_fire;
        for (int i = 1; i < LATENCY - 1; i++) stage_valid_q[i] <= stage_valid_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      stage_data_q[0] <= rd_rsp;
      for (int i = 1; i < LATENCY - 1; i++) stage_data_q[i] <= stage_data_q[i-1];
    end

    assign push_valid = stage_valid_q[LATENCY-2];
    assign push_data  = stage_data_q[LATENCY-2];
  end

  mem_bus_responder_fifo #(
    .DEPTH (QUEUE_SIZE),
    .DATAW (DATAW + TAG_WIDTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_valid),
    .pop_i   (rsp_pop),
    .data_i  (push_data),
    .data_o  (head),
    .empty_o (fifo_empty)
  );

  assign rsp_data = head.data;
  assign rsp_tag  = head.tag;

  a_latency_min: assert property (@(posedge clk) LATENCY >= 1);

  a_credit_bound: assert property (@(posedge clk) disable iff (reset)
    credit_q <= CREDIT_W'(QUEUE_SIZE));

  a_rsp_stable: assert property (@(posedge clk) disable iff (reset)
    (rsp_valid && !rsp_ready) |=> ($stable(rsp_data) && $stable(rsp_tag)));

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder at its default geometry
// (64-byte lines, 1024-line RAM, LATENCY=4, QUEUE_SIZE=8).
module tb_mem_bus_responder;

  localparam int DS = 64;
  localparam int DW = 8 * DS;
  localparam int AW = 26;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_rw;
  logic [AW-1:0] req_addr;
  logic [DS-1:0] req_byteen;
  logic [DW-1:0] req_data;
  logic [TW-1:0] req_tag;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic [TW-1:0] rsp_tag;
  logic          rsp_ready;
  logic          busy;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] pat_a5;
  logic [DW-1:0] pat_ff00;
  logic [DW-1:0] pat_3c;
  logic [DW-1:0] pat_ones;

  mem_bus_responder dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_rw     (req_rw),
    .req_addr   (req_addr),
    .req_byteen (req_byteen),
    .req_data   (req_data),
    .req_tag    (req_tag),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_tag    (rsp_tag),
    .rsp_ready  (rsp_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Advance one cycle; DUT outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid  = 1'b0;
    req_rw     = 1'b0;
    req_addr   = '0;
    req_byteen = '0;
    req_data   = '0;
    req_tag    = '0;
  endtask

  task automatic drive_wr(input logic [AW-1:0] a, input logic [DS-1:0] be,
                          input logic [DW-1:0] d, input logic [TW-1:0] t);
    req_valid  = 1'b1;
    req_rw     = 1'b1;
    req_addr   = a;
    req_byteen = be;
    req_data   = d;
    req_tag    = t;
  endtask

  task automatic drive_rd(input logic [AW-1:0] a, input logic [TW-1:0] t);
    req_valid  = 1'b1;
    req_rw     = 1'b0;
    req_addr   = a;
    req_byteen = '0;
    req_data   = '0;
    req_tag    = t;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    rsp_ready = 1'b1;
    idle();
    tick();
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    reset = 1'b0;
    tick();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", req_ready); end
    $display("test_reset done");
  endtask

  task automatic test_write_read();
    rsp_ready = 1'b1;
    drive_wr(26'h10, '1, pat_a5, 8'h03);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL wr_ready: got %b expected 1", req_ready); end
    tick();
    drive_rd(26'h10, 8'h07);
    tick();
    idle();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_rd_busy: got %b expected 1", busy); end
    for (int k = 2; k < 5; k++) begin
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_rd_early_valid cyc%0d: got %b expected 0", k, rsp_valid); end
      tick();
    end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL wr_rd_valid: got %b expected 1", rsp_valid); end
    checks++; if (rsp_data !== pat_a5) begin errors++; $display("FAIL wr_rd_data: got %h expected %h", rsp_data, pat_a5); end
    checks++; if (rsp_tag !== 8'h07) begin errors++; $display("FAIL wr_rd_tag: got %h expected 07", rsp_tag); end
    $display("rsp tag=%h data[31:0]=%h", rsp_tag, rsp_data[31:0]);
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_no_rsp: got %b expected 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_rd_idle_busy: got %b expected 0", busy); end
  endtask

  // Partial write, aliasing through the upper address bits and byteen=0.
  task automatic test_partial_write();
    rsp_ready = 1'b1;
    drive_wr(26'h2, '1, pat_ones, 8'h00);        tick();
    drive_wr(26'h2, 64'h1, '0, 8'h00);           tick();
    drive_wr(26'h405, '1, pat_3c, 8'h00);        tick();
    drive_wr(26'h5, '0, '0, 8'h00);              tick();
    drive_rd(26'h2, 8'h11);                      tick();
    drive_rd(26'h3FFFC05, 8'h12);                tick();
    idle();
    tick();
    tick();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL partial_valid: got %b expected 1", rsp_valid); end
    checks++; if (rsp_data !== pat_ff00) begin errors++; $display("FAIL partial_data: got %h expected %h", rsp_data, pat_ff00); end
    checks++; if (rsp_tag !== 8'h11) begin errors++; $display("FAIL partial_tag: got %h expected 11", rsp_tag); end
    $display("rsp tag=%h data[31:0]=%h", rsp_tag, rsp_data[31:0]);
    tick();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL alias_valid: got %b expected 1", rsp_valid); end
    checks++; if (rsp_data !== pat_3c) begin errors++; $display("FAIL alias_data: got %h expected %h", rsp_data, pat_3c); end
    checks++; if (rsp_tag !== 8'h12) begin errors++; $display("FAIL alias_tag: got %h expected 12", rsp_tag); end
    $display("rsp tag=%h data[31:0]=%h", rsp_tag, rsp_data[31:0]);
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL partial_drain: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_backpressure_full();
    int accepted;
    accepted  = 0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_rd(26'h10, 8'(8'h20 + i));
      checks++; if (req_ready !== (i < 8)) begin errors++; $display("FAIL full_ready i=%0d: got %b expected %b", i, req_ready, (i < 8)); end
      if (req_ready) accepted++;
      tick();
    end
    idle();
    checks++; if (accepted != 8) begin errors++; $display("FAIL full_accepted: got %0d expected 8", accepted); end
    tick(); tick(); tick();
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_ready_held: got %b expected 0", req_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy: got %b expected 1", busy); end
    checks++; if (rsp_valid !== 1'b1 || rsp_tag !== 8'h20) begin errors++; $display("FAIL full_head: got valid=%b tag=%h expected valid=1 tag=20", rsp_valid, rsp_tag); end
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_tag !== 8'(8'h20 + k) || rsp_data !== pat_a5) begin
        errors++; $display("FAIL drain_rsp k=%0d: got valid=%b tag=%h expected valid=1 tag=%h", k, rsp_valid, rsp_tag, 8'(8'h20 + k));
      end
      $display("rsp tag=%h data[31:0]=%h", rsp_tag, rsp_data[31:0]);
      if (k == 0) begin
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL no_bypass_ready: got %b expected 0", req_ready); end
      end
      if (k == 1) begin
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_pop: got %b expected 1", req_ready); end
      end
      tick();
    end
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL drain_done: got valid=%b busy=%b expected 0 0", rsp_valid, busy); end
  endtask

  task automatic test_back_to_back();
    logic exp_valid;
    rsp_ready = 1'b1;
    for (int c = 0; c < 22; c++) begin
      if (c < 16) drive_rd(26'h10, 8'(c));
      else        idle();
      if (c < 16) begin
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready c=%0d: got %b expected 1", c, req_ready); end
      end
      exp_valid = (c >= 4) && (c < 20);
      checks++; if (rsp_valid !== exp_valid) begin errors++; $display("FAIL b2b_valid c=%0d: got %b expected %b", c, rsp_valid, exp_valid); end
      if (exp_valid) begin
        checks++; if (rsp_tag !== 8'(c - 4)) begin errors++; $display("FAIL b2b_tag c=%0d: got %h expected %h", c, rsp_tag, 8'(c - 4)); end
        $display("rsp tag=%h data[31:0]=%h", rsp_tag, rsp_data[31:0]);
      end
      if (c == 19) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_last: got %b expected 1", busy); end
      end
      if (c == 20) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_clear: got %b expected 0", busy); end
      end
      tick();
    end
  endtask

  // Random response stalls; even tags read line 0x10, odd tags line 0x2.
  task automatic test_stall();
    int            sent;
    int            got;
    logic          prev_stall;
    logic [DW-1:0] held_data;
    logic [TW-1:0] held_tag;
    logic [DW-1:0] exp_data;
    sent       = 0;
    got        = 0;
    prev_stall = 1'b0;
    held_data  = '0;
    held_tag   = '0;
    for (int c = 0; c < 400 && got < 12; c++) begin
      if (sent < 12) drive_rd((sent % 2 == 0) ? 26'h10 : 26'h2, 8'(8'h40 + sent));
      else           idle();
      rsp_ready = 1'($urandom_range(0, 1));
      if (prev_stall) begin
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== held_data || rsp_tag !== held_tag) begin
          errors++; $display("FAIL stall_stable c=%0d: got valid=%b tag=%h expected valid=1 tag=%h", c, rsp_valid, rsp_tag, held_tag);
        end
      end
      if (rsp_valid && rsp_ready) begin
        exp_data = (got % 2 == 0) ? pat_a5 : pat_ff00;
        checks++; if (rsp_tag !== 8'(8'h40 + got) || rsp_data !== exp_data) begin
          errors++; $display("FAIL stall_order got#%0d: got tag=%h expected tag=%h", got, rsp_tag, 8'(8'h40 + got));
        end
        $display("rsp tag=%h data[31:0]=%h", rsp_tag, rsp_data[31:0]);
        got++;
      end
      prev_stall = rsp_valid && !rsp_ready;
      held_data  = rsp_data;
      held_tag   = rsp_tag;
      if (sent < 12 && req_ready) sent++;
      tick();
    end
    idle();
    rsp_ready = 1'b1;
    checks++; if (got != 12) begin errors++; $display("FAIL stall_count: got %0d expected 12 (cycle budget)", got); end
    tick(); tick();
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL stall_dup: got valid=%b busy=%b expected 0 0", rsp_valid, busy); end
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_rd(26'h10, 8'(8'h50 + i));
      tick();
    end
    idle();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
    reset = 1'b1;
    tick();
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b0) begin
      errors++; $display("FAIL mid_reset_state: got valid=%b busy=%b ready=%b expected 0 0 0", rsp_valid, busy, req_ready);
    end
    reset = 1'b0;
    tick();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_back: got %b expected 1", req_ready); end
    for (int k = 0; k < 8; k++) begin
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_stale k=%0d: got tag=%h valid=%b expected 0", k, rsp_tag, rsp_valid); end
      tick();
    end
    drive_rd(26'h10, 8'h5A);
    tick();
    idle();
    tick(); tick(); tick();
    checks++; if (rsp_valid !== 1'b1 || rsp_tag !== 8'h5A || rsp_data !== pat_a5) begin
      errors++; $display("FAIL mid_ram_kept: got valid=%b tag=%h data[31:0]=%h expected 1 5a a5a5a5a5", rsp_valid, rsp_tag, rsp_data[31:0]);
    end
    $display("rsp tag=%h data[31:0]=%h", rsp_tag, rsp_data[31:0]);
    tick();
  endtask

  initial begin
    pat_a5   = {64{8'hA5}};
    pat_ff00 = {{63{8'hFF}}, 8'h00};
    pat_3c   = {64{8'h3C}};
    pat_ones = '1;
    test_reset();
    test_write_read();
    test_partial_write();
    test_backpressure_full();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
